// File: rtl/video_sig_gen.sv
// Raster timing generator: hcount/vcount, syncs, active-draw, new-frame pulse, frame count.
// Optional VSG_LINE_IRQ_EN adds a programmable one-cycle line interrupt.
module video_sig_gen #(
  parameter int ACTIVE_H      = 1280,
  parameter int H_FRONT_PORCH = 110,
  parameter int H_SYNC_WIDTH  = 40,
  parameter int H_BACK_PORCH  = 220,
  parameter int ACTIVE_V      = 720,
  parameter int V_FRONT_PORCH = 5,
  parameter int V_SYNC_WIDTH  = 5,
  parameter int V_BACK_PORCH  = 20,
  parameter int FPS           = 60
) (
  input  logic        clk_pixel_in,
  input  logic        rst_n_in,
`ifdef VSG_LINE_IRQ_EN
  input  logic [9:0]  line_match_in,
  output logic        line_irq_out,
`endif
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out
);

  localparam int TOTAL_H = ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int TOTAL_V = ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

  localparam logic [10:0] LP_H_LAST   = 11'(TOTAL_H - 1);
  localparam logic [9:0]  LP_V_LAST   = 10'(TOTAL_V - 1);
  localparam logic [10:0] LP_H_ACT    = 11'(ACTIVE_H);
  localparam logic [9:0]  LP_V_ACT    = 10'(ACTIVE_V);
  localparam logic [10:0] LP_HS_START = 11'(ACTIVE_H + H_FRONT_PORCH);
  localparam logic [10:0] LP_HS_END   = 11'(ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [9:0]  LP_VS_START = 10'(ACTIVE_V + V_FRONT_PORCH);
  localparam logic [9:0]  LP_VS_END   = 10'(ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH);
  localparam logic [5:0]  LP_FC_LAST  = 6'(FPS - 1);

  logic [1:0]  r_rst_sync;
  logic        w_rst_n;
  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic        r_hs;
  logic        r_vs;
  logic        r_ad;
  logic        r_nf;
  logic [5:0]  r_fc;
  logic [10:0] w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic        w_h_wrap;
  logic        w_nf_nxt;

  // Assertion propagates immediately; release is delayed two pixel clocks.
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n  = r_rst_sync[1];
  assign w_h_wrap = (r_hcount == LP_H_LAST);
  assign w_h_nxt  = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
  assign w_v_nxt  = !w_h_wrap ? r_vcount :
                    (r_vcount == LP_V_LAST) ? 10'd0 : r_vcount + 10'd1;
  assign w_nf_nxt = (w_h_nxt == LP_H_ACT) && (w_v_nxt == LP_V_ACT);

  // Flags decode the next-state counters so they land with the coordinates they describe.
  always_ff @(posedge clk_pixel_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hcount <= LP_H_LAST;
      r_vcount <= LP_V_LAST;
      r_hs     <= 1'b0;
      r_vs     <= 1'b0;
      r_ad     <= 1'b0;
      r_nf     <= 1'b0;
      r_fc     <= 6'd0;
    end else begin
      r_hcount <= w_h_nxt;
      r_vcount <= w_v_nxt;
      r_hs     <= (w_h_nxt >= LP_HS_START) && (w_h_nxt < LP_HS_END);
      r_vs     <= (w_v_nxt >= LP_VS_START) && (w_v_nxt < LP_VS_END);
      r_ad     <= (w_h_nxt < LP_H_ACT) && (w_v_nxt < LP_V_ACT);
      r_nf     <= w_nf_nxt;
      if (w_nf_nxt) begin
        r_fc <= (r_fc == LP_FC_LAST) ? 6'd0 : r_fc + 6'd1;
      end
    end
  end

`ifdef VSG_LINE_IRQ_EN
  logic r_line_irq;

  // Out-of-range match values simply never equal a legal line number.
  always_ff @(posedge clk_pixel_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_line_irq <= 1'b0;
    end else begin
      r_line_irq <= (w_h_nxt == 11'd0) && (w_v_nxt == line_match_in);
    end
  end

  assign line_irq_out = r_line_irq;
`endif

  assign hcount_out = r_hcount;
  assign vcount_out = r_vcount;
  assign hs_out     = r_hs;
  assign vs_out     = r_vs;
  assign ad_out     = r_ad;
  assign nf_out     = r_nf;
  assign fc_out     = r_fc;

endmodule
